// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe: MEM stage of the pipelined CPU.
//   EX/MEM register -> NUM_BANKS synchronous data banks + result mux -> MEM/WB register.
//   Carries a valid bit, supports stall (hold) and flush (bubble), and flags accesses
//   whose address is >= DEPTH or whose bank select is >= NUM_BANKS.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   stall_i          hold both pipeline registers and block the RAM write
//   flush_i          load a bubble into EX/MEM (wins over stall)
//   *_ex             execute-stage fields: valid, wbs, wme, mm (bank), wm (mux), ni,
//                    alu_result (address / result), write_data (store data)
//   *_wb             writeback-stage fields: valid, wbs, ni, mem_data (load data),
//                    alu_result (mux output), fault (out-of-range access)
module memory_stage_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_ex,
  input  logic              wbs_ex,
  input  logic              wme_ex,
  input  logic [BANK_W-1:0] mm_ex,
  input  logic              wm_ex,
  input  logic              ni_ex,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [DATA_W-1:0] write_data_ex,
  output logic              valid_wb,
  output logic              wbs_wb,
  output logic              ni_wb,
  output logic [DATA_W-1:0] mem_data_wb,
  output logic [DATA_W-1:0] alu_result_wb,
  output logic              fault_wb
);

  // Range limits widened by one bit so DEPTH == 2**DATA_W or NUM_BANKS == 2**BANK_W still fit.
  localparam logic [DATA_W:0] DepthExt    = (DATA_W + 1)'(DEPTH);
  localparam logic [BANK_W:0] NumBanksExt = (BANK_W + 1)'(NUM_BANKS);

  // ---------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------
  logic              valid_q, valid_d;
  logic              wbs_q, wbs_d;
  logic              wme_q, wme_d;
  logic [BANK_W-1:0] mm_q, mm_d;
  logic              wm_q, wm_d;
  logic              ni_q, ni_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  always_comb begin
    valid_d      = valid_q;
    wbs_d        = wbs_q;
    wme_d        = wme_q;
    mm_d         = mm_q;
    wm_d         = wm_q;
    ni_d         = ni_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      wbs_d        = 1'b0;
      wme_d        = 1'b0;
      mm_d         = '0;
      wm_d         = 1'b0;
      ni_d         = 1'b0;
      alu_result_d = '0;
      write_data_d = '0;
    end else if (!stall_i) begin
      valid_d      = valid_ex;
      wbs_d        = wbs_ex;
      wme_d        = wme_ex;
      mm_d         = mm_ex;
      wm_d         = wm_ex;
      ni_d         = ni_ex;
      alu_result_d = alu_result_ex;
      write_data_d = write_data_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wbs_q        <= 1'b0;
      wme_q        <= 1'b0;
      mm_q         <= '0;
      wm_q         <= 1'b0;
      ni_q         <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      wbs_q        <= wbs_d;
      wme_q        <= wme_d;
      mm_q         <= mm_d;
      wm_q         <= wm_d;
      ni_q         <= ni_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data banks
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [ADDR_W-1:0] addr_m;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] result_m;

  always_comb begin
    addr_m   = alu_result_q[ADDR_W-1:0];
    // Whole ALU result is compared, so nonzero upper bits count as out of range.
    in_range = ({1'b0, alu_result_q} < DepthExt) && ({1'b0, mm_q} < NumBanksExt);
    mem_we   = valid_q & wme_q & in_range & ~stall_i & ~rst;
    rd_data  = in_range ? mem_q[mm_q][addr_m] : '0;
    result_m = wm_q ? write_data_q : alu_result_q;
  end

  // Non-blocking write: a read of the same word on the same edge sees the old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mm_q][addr_m] <= write_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  logic              valid_wb_q;
  logic              wbs_wb_q;
  logic              ni_wb_q;
  logic [DATA_W-1:0] mem_data_wb_q;
  logic [DATA_W-1:0] alu_result_wb_q;
  logic              fault_wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_wb_q      <= 1'b0;
      wbs_wb_q        <= 1'b0;
      ni_wb_q         <= 1'b0;
      mem_data_wb_q   <= '0;
      alu_result_wb_q <= '0;
      fault_wb_q      <= 1'b0;
    end else if (!stall_i) begin
      valid_wb_q      <= valid_q;
      wbs_wb_q        <= wbs_q;
      ni_wb_q         <= ni_q;
      mem_data_wb_q   <= rd_data;
      alu_result_wb_q <= result_m;
      fault_wb_q      <= valid_q & ~in_range;
    end
  end

  assign valid_wb      = valid_wb_q;
  assign wbs_wb        = wbs_wb_q;
  assign ni_wb         = ni_wb_q;
  assign mem_data_wb   = mem_data_wb_q;
  assign alu_result_wb = alu_result_wb_q;
  assign fault_wb      = fault_wb_q;

endmodule
